// File: rtl/microcode_sequencer_if.sv
// Bus between the microcode sequencer, its microcode ROM, the instruction
// register and the datapath control inputs.
interface microcode_sequencer_if;
    logic        start;
    logic        halt_req;
    logic        single_step;
    logic        step_pulse;
    logic [7:0]  ir_opcode;
    logic [31:0] uword_in;
    logic [15:0] uaddr;
    logic [31:0] ctrl_out;
    logic        running;
    logic        halted;
    logic        illegal_op;
    logic        instr_done;
    logic [15:0] instr_count;

    modport slave (
        input  start, halt_req, single_step, step_pulse, ir_opcode, uword_in,
        output uaddr, ctrl_out, running, halted, illegal_op, instr_done, instr_count
    );

    modport master (
        output start, halt_req, single_step, step_pulse, ir_opcode, uword_in,
        input  uaddr, ctrl_out, running, halted, illegal_op, instr_done, instr_count
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks fetch/decode then execute steps of the opcode
// page until an end marker, with run/halt, single-step and illegal trapping.
module microcode_sequencer #(
    parameter int unsigned FETCH_STEPS = 3,
    parameter int unsigned MAX_STEP    = 15,
    parameter int unsigned NUM_OPCODES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    microcode_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [7:0] LAST_FETCH   = 8'(FETCH_STEPS - 1);
    localparam logic [7:0] LAST_STEP    = 8'(MAX_STEP);
    localparam logic [8:0] OPCODE_LIMIT = 9'(NUM_OPCODES);

    state_t      state_q, state_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  page_q, page_d;
    logic        illegal_q, illegal_d;
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;
    logic        advance;

    assign advance = (state_q == RUN) && (!bus.single_step || bus.step_pulse);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            page_q    <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            page_q    <= page_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        page_d    = page_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    step_d  = '0;
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d   = RUN;
                    step_d    = '0;
                    illegal_d = 1'b0;
                end
            end
            RUN: begin
                if (advance) begin
                    if (step_q < LAST_FETCH) begin
                        step_d = step_q + 8'd1;
                    end else if (step_q == LAST_FETCH) begin
                        // Last decode step: latch the page or trap without retiring
                        if ({1'b0, bus.ir_opcode} < OPCODE_LIMIT) begin
                            page_d = bus.ir_opcode;
                            step_d = step_q + 8'd1;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = HALT;
                            step_d    = '0;
                        end
                    end else if ((bus.uword_in == '0) || (step_q == LAST_STEP)) begin
                        step_d  = '0;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        if (bus.halt_req) begin
                            state_d = HALT;
                        end
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.uaddr       = {page_q, step_q};
    assign bus.ctrl_out    = advance ? bus.uword_in : '0;
    assign bus.running     = (state_q == RUN);
    assign bus.halted      = (state_q == HALT);
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_done  = done_q;
    assign bus.instr_count = count_q;
endmodule
